aes_ahb_slave: RTL and testbench
================================

# aes_ahb_slave

AHB-Lite slave front end of the AES accelerator: decodes CPU bus transfers into control/status registers and two 4-word (128-bit) FIFOs, and exchanges 32-bit words with the AES controller over a shift handshake. It is the bus-side counterpart of the controller. It generates `start`, `data_type`, `enc_dec` and `data_received`, and consumes `ahb_mode`, `ahb_shift_en` and `done_chg_key`.

## Interface
- DEPTH, 4, entries per FIFO (one 128-bit block); fixed, not overridable.
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- hsel, hwrite  in  1  AHB select / write
- htrans  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hsize  in  3  AHB size; only 3'b010 (word) is legal
- haddr  in  4  byte address inside the 16-byte window
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data (data phase)
- hreadyout, hresp  out  1  AHB ready / error response
- start  out  1  one-cycle pulse to controller
- data_type  out  1  level: 1 = key block, 0 = payload block
- enc_dec  out  1  level: 0 = encrypt, 1 = decrypt
- data_received  out  1  one-cycle pulse when input FIFO reaches 4 words
- ahb_mode  in  1  controller direction: 0 = fetch input word, 1 = write output word
- ahb_shift_en  in  1  controller shift strobe, one word per asserted cycle
- core_wdata  out  32  head of input FIFO (valid when in_count>0)
- core_rdata  in  32  word from core, captured when ahb_mode=1 and ahb_shift_en=1
- done_chg_key  in  1  key-load-complete pulse from controller

## Operation
- Register map (word offsets): 0x0 CTRL (W/R), 0x4 STATUS (R), 0x8 DATA_IN (W), 0xC DATA_OUT (R).
- CTRL: bit0 start (write-1 pulses `start`, reads 0), bit1 data_type, bit2 enc_dec. Bits 1-2 are stored and read back.
- STATUS: bit0 key_done (sticky, set by done_chg_key, cleared by a STATUS read), bit1 out_valid (out_count==4), bit2 in_full, bit3 in_empty, bit4 out_overflow (sticky, cleared by a STATUS read), bits[7:5] out_count.
- DATA_IN write pushes hwdata into the input FIFO. A controller fetch (ahb_mode=0, ahb_shift_en=1) with in_count>0 pops the head. A fetch while empty is ignored.
- DATA_OUT read returns the output FIFO head and pops it. A controller write (ahb_mode=1, ahb_shift_en=1) pushes core_rdata. A push while full is dropped and sets out_overflow.
- Same-cycle push and pop on one FIFO: both occur and the count is unchanged. Pointers wrap modulo 4. Counts are 3 bits (0..4).
- data_received pulses on the cycle in_count transitions to 4.
- Error response (two-cycle: hresp=1/hreadyout=0, then hresp=1/hreadyout=1) for any of the following:
  - hsize≠word;
  - write to STATUS/DATA_OUT;
  - read of DATA_IN;
  - DATA_IN write when full;
  - DATA_OUT read when empty.
  An erroring transfer has no side effect.
- The bus FSM has three states: IDLE_OK (hreadyout=1, hresp=0), ERR1, ERR2.
  - IDLE_OK→ERR1 when a latched address-phase transfer is illegal.
  - ERR1→ERR2 unconditionally.
  - ERR2→IDLE_OK. If a new legal transfer is sampled in ERR2, it is accepted normally.
- HTRANS IDLE/BUSY or hsel=0: no transfer, OKAY response.

## Timing
- Address phase is sampled when hreadyout=1. The data phase is the following cycle. Writes and pops commit at the end of the data phase.
- Zero wait states for legal transfers. hrdata is valid in the data phase from registered address/state. DATA_OUT shows the pre-pop head.
- start is asserted exactly the cycle after the CTRL data phase, for 1 cycle. data_type/enc_dec update at the same edge.
- core_wdata reflects the new head the cycle after a pop. A DATA_IN write into an empty FIFO is visible on core_wdata the next cycle.
- key_done sets the cycle after done_chg_key. If a STATUS read clears key_done in the same cycle a set arrives, set wins.
- Reset values: hrdata=0, hreadyout=1, hresp=0, start=0, data_type=0, enc_dec=0, data_received=0, core_wdata=0. Both FIFOs are empty and all sticky bits 0. Reset mid-transfer aborts and discards FIFO contents.

## Test plan
- After reset, read STATUS → 0x08 (in_empty only), OKAY, hreadyout=1.
- Write CTRL=0x3 → start high for exactly 1 cycle, data_type=1, enc_dec=0. CTRL reads back 0x2.
- Write DATA_IN 0x11111111..0x44444444 → data_received pulses once after the 4th write. A 5th write gets a two-cycle ERROR and the FIFO is unchanged. Four controller fetches yield 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order.
- Controller pushes 0xA0..0xA3 with ahb_mode=1 → STATUS bit1=1, out_count=4. Four DATA_OUT reads return 0xA0..0xA3. A 5th read gets ERROR. A 5th push while full sets out_overflow.
- With in_count=2, a DATA_IN write and a controller fetch in the same cycle → in_count stays 2 and FIFO order is preserved.
- Pulse done_chg_key → STATUS bit0=1; a second STATUS read → 0. hsize=byte access to CTRL → ERROR, no side effect.

Source files
------------

// File: rtl/aes_ahb_slave.sv
// -----------------------------------------------------------------------------
// aes_ahb_slave
//
// AHB-Lite slave front end of the AES accelerator. It decodes CPU transfers
// into a 16-byte register window and moves 32-bit words to and from the AES
// controller through two 4-word FIFOs.
//
// Register map (word offsets):
//   0x0 CTRL     W/R  bit0 start (write-1 pulse, reads 0), bit1 data_type,
//                     bit2 enc_dec
//   0x4 STATUS   R    bit0 key_done, bit1 out_valid, bit2 in_full,
//                     bit3 in_empty, bit4 out_overflow, bits[7:5] out_count
//   0x8 DATA_IN  W    push into the input FIFO
//   0xC DATA_OUT R    pop from the output FIFO (returns the pre-pop head)
//
// Ports:
//   clk, n_rst           clock (rising edge), asynchronous active-low reset
//   hsel .. hwdata       AHB-Lite address/data phase inputs
//   hrdata, hreadyout,
//   hresp                AHB-Lite data phase outputs
//   start                one-cycle pulse to the controller
//   data_type, enc_dec   control levels to the controller
//   data_received        one-cycle pulse when the input FIFO fills
//   ahb_mode,
//   ahb_shift_en         controller handshake (0 = fetch, 1 = write back)
//   core_wdata           input FIFO head, 0 when empty
//   core_rdata           word written back by the controller
//   done_chg_key         key-load-complete pulse from the controller
// -----------------------------------------------------------------------------
module aes_ahb_slave (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [3:0]  haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic        start,
  output logic        data_type,
  output logic        enc_dec,
  output logic        data_received,
  input  logic        ahb_mode,
  input  logic        ahb_shift_en,
  output logic [31:0] core_wdata,
  input  logic [31:0] core_rdata,
  input  logic        done_chg_key
);

  localparam int DEPTH = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIN    = 2'd2;
  localparam logic [1:0] REG_DOUT   = 2'd3;

  typedef enum logic [1:0] {IDLE_OK, ERR1, ERR2} bus_state_e;

  bus_state_e  state_q, state_d;
  logic        dp_valid_q, dp_valid_d;
  logic        dp_write_q, dp_write_d;
  logic [1:0]  dp_reg_q, dp_reg_d;
  logic        start_q, start_d;
  logic        data_type_q, data_type_d;
  logic        enc_dec_q, enc_dec_d;
  logic        key_done_q, key_done_d;
  logic        out_ovf_q, out_ovf_d;
  logic        data_rx_q, data_rx_d;
  logic [1:0]  in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
  logic [1:0]  out_wr_ptr_q, out_wr_ptr_d, out_rd_ptr_q, out_rd_ptr_d;
  logic [2:0]  in_count_q, in_count_d, out_count_q, out_count_d;
  logic [31:0] in_mem_q  [DEPTH];
  logic [31:0] out_mem_q [DEPTH];

  logic in_push, in_pop, out_push, out_pop, out_push_req;
  logic ctrl_wr, status_rd, illegal;

  // Address bits below word granularity and the low htrans bit carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{haddr[1:0], htrans[0]};

  // Data-phase side effects, all committed at the end of the data phase.
  assign ctrl_wr   = dp_valid_q &&  dp_write_q && (dp_reg_q == REG_CTRL);
  assign status_rd = dp_valid_q && !dp_write_q && (dp_reg_q == REG_STATUS);
  assign in_push   = dp_valid_q &&  dp_write_q && (dp_reg_q == REG_DIN);
  assign out_pop   = dp_valid_q && !dp_write_q && (dp_reg_q == REG_DOUT);
  assign in_pop    = !ahb_mode && ahb_shift_en && (in_count_q != 3'd0);

  // A full output FIFO still accepts a push when the bus pops it in the same cycle.
  assign out_push_req = ahb_mode && ahb_shift_en;
  assign out_push     = out_push_req && ((out_count_q != 3'(DEPTH)) || out_pop);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    in_count_d   = in_count_q;
    out_count_d  = out_count_q;
    in_wr_ptr_d  = in_push  ? in_wr_ptr_q  + 2'd1 : in_wr_ptr_q;
    in_rd_ptr_d  = in_pop   ? in_rd_ptr_q  + 2'd1 : in_rd_ptr_q;
    out_wr_ptr_d = out_push ? out_wr_ptr_q + 2'd1 : out_wr_ptr_q;
    out_rd_ptr_d = out_pop  ? out_rd_ptr_q + 2'd1 : out_rd_ptr_q;
    case ({in_push, in_pop})
      2'b10:   in_count_d = in_count_q + 3'd1;
      2'b01:   in_count_d = in_count_q - 3'd1;
      default: in_count_d = in_count_q;
    endcase
    case ({out_push, out_pop})
      2'b10:   out_count_d = out_count_q + 3'd1;
      2'b01:   out_count_d = out_count_q - 3'd1;
      default: out_count_d = out_count_q;
    endcase

    start_d     = ctrl_wr && hwdata[0];
    data_type_d = ctrl_wr ? hwdata[1] : data_type_q;
    enc_dec_d   = ctrl_wr ? hwdata[2] : enc_dec_q;
    // Sticky bits: a set in the same cycle as the clearing read wins.
    key_done_d  = done_chg_key || (key_done_q && !status_rd);
    out_ovf_d   = (out_push_req && !out_push) || (out_ovf_q && !status_rd);
    data_rx_d   = (in_count_d == 3'(DEPTH)) && (in_count_q != 3'(DEPTH));
  end

  // Legality is judged against the FIFO levels the data phase will start with,
  // so a back-to-back transfer sees the effect of the one ahead of it.
  always_comb begin
    illegal = (hsize != 3'b010);
    case (haddr[3:2])
      REG_CTRL:   illegal = illegal;
      REG_STATUS: illegal = illegal || hwrite;
      REG_DIN:    illegal = illegal || !hwrite || (in_count_d == 3'(DEPTH));
      default:    illegal = illegal || hwrite || (out_count_d == 3'd0);
    endcase
  end

  // Bus FSM: next state and the latched data-phase descriptor.
  always_comb begin
    state_d    = state_q;
    dp_valid_d = 1'b0;
    dp_write_d = dp_write_q;
    dp_reg_d   = dp_reg_q;
    case (state_q)
      IDLE_OK, ERR2: begin
        state_d = IDLE_OK;
        if (hsel && htrans[1]) begin
          if (illegal) begin
            state_d = ERR1;
          end else begin
            dp_valid_d = 1'b1;
            dp_write_d = hwrite;
            dp_reg_d   = haddr[3:2];
          end
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE_OK;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE_OK;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_reg_q     <= 2'd0;
      start_q      <= 1'b0;
      data_type_q  <= 1'b0;
      enc_dec_q    <= 1'b0;
      key_done_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      data_rx_q    <= 1'b0;
      in_wr_ptr_q  <= 2'd0;
      in_rd_ptr_q  <= 2'd0;
      out_wr_ptr_q <= 2'd0;
      out_rd_ptr_q <= 2'd0;
      in_count_q   <= 3'd0;
      out_count_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_reg_q     <= dp_reg_d;
      start_q      <= start_d;
      data_type_q  <= data_type_d;
      enc_dec_q    <= enc_dec_d;
      key_done_q   <= key_done_d;
      out_ovf_q    <= out_ovf_d;
      data_rx_q    <= data_rx_d;
      in_wr_ptr_q  <= in_wr_ptr_d;
      in_rd_ptr_q  <= in_rd_ptr_d;
      out_wr_ptr_q <= out_wr_ptr_d;
      out_rd_ptr_q <= out_rd_ptr_d;
      in_count_q   <= in_count_d;
      out_count_q  <= out_count_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the counts gate every read
  // of it, so stale words are never observable.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_ptr_q]   <= hwdata;
    if (out_push) out_mem_q[out_wr_ptr_q] <= core_rdata;
  end

  always_comb begin
    hrdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_reg_q)
        REG_CTRL:   hrdata = {29'd0, enc_dec_q, data_type_q, 1'b0};
        REG_STATUS: hrdata = {24'd0, out_count_q, out_ovf_q,
                              (in_count_q == 3'd0), (in_count_q == 3'(DEPTH)),
                              (out_count_q == 3'(DEPTH)), key_done_q};
        REG_DOUT:   hrdata = out_mem_q[out_rd_ptr_q];
        default:    hrdata = '0;
      endcase
    end
  end

  assign hreadyout     = (state_q != ERR1);
  assign hresp         = (state_q != IDLE_OK);
  assign start         = start_q;
  assign data_type     = data_type_q;
  assign enc_dec       = enc_dec_q;
  assign data_received = data_rx_q;
  assign core_wdata    = (in_count_q != 3'd0) ? in_mem_q[in_rd_ptr_q] : '0;

endmodule

// File: tb/tb_aes_ahb_slave.sv
// -----------------------------------------------------------------------------
// tb_aes_ahb_slave
//
// Directed testbench for aes_ahb_slave. Each scenario task drives its own
// stimulus and compares DUT outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_aes_ahb_slave;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  haddr;
  logic [31:0] hwdata, hrdata;
  logic        hreadyout, hresp;
  logic        start, data_type, enc_dec, data_received;
  logic        ahb_mode, ahb_shift_en;
  logic [31:0] core_wdata, core_rdata;
  logic        done_chg_key;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int drx_cnt   = 0;

  localparam logic [3:0] A_CTRL = 4'h0, A_STATUS = 4'h4, A_DIN = 4'h8, A_DOUT = 4'hC;
  localparam logic [2:0] SZ_WORD = 3'b010, SZ_BYTE = 3'b000;

  aes_ahb_slave dut (
    .clk(clk), .n_rst(n_rst), .hsel(hsel), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .start(start), .data_type(data_type),
    .enc_dec(enc_dec), .data_received(data_received), .ahb_mode(ahb_mode),
    .ahb_shift_en(ahb_shift_en), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .done_chg_key(done_chg_key)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (start === 1'b1) start_cnt++;
    if (data_received === 1'b1) drx_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One AHB transfer. resp: 0 = OKAY, 1 = well-formed two-cycle ERROR, 2 = malformed.
  task automatic bus_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic key_in_dp,
                          output logic [31:0] rdata, output int resp);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata; done_chg_key = key_in_dp;
    @(negedge clk);
    rdata = hrdata;
    if (hresp === 1'b0 && hreadyout === 1'b1) begin
      resp = 0;
    end else if (hresp === 1'b1 && hreadyout === 1'b0) begin
      @(posedge clk); #1;
      done_chg_key = 1'b0;
      @(negedge clk);
      resp = (hresp === 1'b1 && hreadyout === 1'b1) ? 1 : 2;
    end else begin
      resp = 2;
    end
    @(posedge clk); #1;
    done_chg_key = 1'b0;
  endtask

  task automatic ctrl_fetch(output logic [31:0] w);
    w = core_wdata;
    ahb_mode = 1'b0; ahb_shift_en = 1'b1;
    @(posedge clk); #1;
    ahb_shift_en = 1'b0;
  endtask

  task automatic ctrl_push(input logic [31:0] w);
    ahb_mode = 1'b1; core_rdata = w; ahb_shift_en = 1'b1;
    @(posedge clk); #1;
    ahb_shift_en = 1'b0; ahb_mode = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int resp;
    n_rst = 1'b0;
    hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hsize = SZ_WORD; haddr = 4'h0;
    hwdata = '0; ahb_mode = 1'b0; ahb_shift_en = 1'b0; core_rdata = '0; done_chg_key = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
    checks++; if (hreadyout !== 1'b1) begin failures++; $display("FAIL rst_hreadyout got=%b exp=1", hreadyout); end
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
    checks++; if ({start, data_type, enc_dec, data_received} !== 4'b0000) begin
      failures++; $display("FAIL rst_ctrl_outs got=%b exp=0000", {start, data_type, enc_dec, data_received}); end
    checks++; if (core_wdata !== 32'h0) begin failures++; $display("FAIL rst_core_wdata got=%h exp=0", core_wdata); end
    @(posedge clk); #1;
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 0) begin failures++; $display("FAIL rst_status_resp got=%0d exp=0", resp); end
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL rst_status got=%h exp=08", rd); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    int resp;
    int base;
    base = start_cnt;
    bus_xfer(1'b1, A_CTRL, 32'h3, SZ_WORD, 1'b0, rd, resp);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL ctrl_start_hi got=%b exp=1", start); end
    checks++; if ({data_type, enc_dec} !== 2'b10) begin failures++; $display("FAIL ctrl_levels got=%b exp=10", {data_type, enc_dec}); end
    @(posedge clk); #1;
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL ctrl_start_lo got=%b exp=0", start); end
    checks++; if (start_cnt - base !== 1) begin failures++; $display("FAIL ctrl_start_cycles got=%0d exp=1", start_cnt - base); end
    bus_xfer(1'b0, A_CTRL, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h2) begin failures++; $display("FAIL ctrl_readback got=%h exp=2", rd); end
    bus_xfer(1'b1, A_CTRL, 32'h4, SZ_WORD, 1'b0, rd, resp);
    bus_xfer(1'b0, A_CTRL, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL ctrl_readback2 got=%h exp=4", rd); end
    checks++; if ({data_type, enc_dec} !== 2'b01) begin failures++; $display("FAIL ctrl_levels2 got=%b exp=01", {data_type, enc_dec}); end
  endtask

  task automatic test_in_fifo();
    logic [31:0] words [4];
    logic [31:0] rd, w;
    int resp, base;
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    base = drx_cnt;
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b1, A_DIN, words[i], SZ_WORD, 1'b0, rd, resp);
      checks++; if (resp !== 0) begin failures++; $display("FAIL din_write%0d resp got=%0d exp=0", i, resp); end
    end
    checks++; if (data_received !== 1'b1) begin failures++; $display("FAIL din_data_received got=%b exp=1", data_received); end
    bus_xfer(1'b1, A_DIN, 32'h55555555, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL din_full_err resp got=%0d exp=1", resp); end
    checks++; if (drx_cnt - base !== 1) begin failures++; $display("FAIL din_rx_pulses got=%0d exp=1", drx_cnt - base); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h04) begin failures++; $display("FAIL din_status_full got=%h exp=04", rd); end
    for (int i = 0; i < 4; i++) begin
      ctrl_fetch(w);
      checks++; if (w !== words[i]) begin failures++; $display("FAIL din_fetch%0d got=%h exp=%h", i, w, words[i]); end
    end
    ctrl_fetch(w);
    checks++; if (w !== 32'h0) begin failures++; $display("FAIL din_fetch_empty got=%h exp=0", w); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL din_status_empty got=%h exp=08", rd); end
  endtask

  task automatic test_out_fifo();
    logic [31:0] rd;
    int resp;
    for (int i = 0; i < 4; i++) ctrl_push(32'hA0 + 32'(i));
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h8A) begin failures++; $display("FAIL dout_status_full got=%h exp=8a", rd); end
    ctrl_push(32'hA4);
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h9A) begin failures++; $display("FAIL dout_overflow got=%h exp=9a", rd); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h8A) begin failures++; $display("FAIL dout_overflow_clr got=%h exp=8a", rd); end
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b0, A_DOUT, '0, SZ_WORD, 1'b0, rd, resp);
      checks++; if (resp !== 0 || rd !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL dout_read%0d got=%h resp=%0d exp=%h resp=0", i, rd, resp, 32'hA0 + 32'(i)); end
    end
    bus_xfer(1'b0, A_DOUT, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL dout_empty_err resp got=%0d exp=1", resp); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL dout_status_end got=%h exp=08", rd); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd, w;
    int resp;
    logic [31:0] exp_rest [4];
    exp_rest = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    bus_xfer(1'b1, A_DIN, 32'hB0, SZ_WORD, 1'b0, rd, resp);
    bus_xfer(1'b1, A_DIN, 32'hB1, SZ_WORD, 1'b0, rd, resp);
    // DATA_IN write data phase coincides with a controller fetch.
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = A_DIN; hsize = SZ_WORD;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hB2;
    w = core_wdata; ahb_mode = 1'b0; ahb_shift_en = 1'b1;
    @(negedge clk);
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL simul_resp got=%b exp=0", hresp); end
    @(posedge clk); #1;
    ahb_shift_en = 1'b0;
    checks++; if (w !== 32'hB0) begin failures++; $display("FAIL simul_fetch got=%h exp=b0", w); end
    // Count must still be 2: exactly two more writes fill the FIFO.
    bus_xfer(1'b1, A_DIN, 32'hB3, SZ_WORD, 1'b0, rd, resp);
    bus_xfer(1'b1, A_DIN, 32'hB4, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 0) begin failures++; $display("FAIL simul_fill resp got=%0d exp=0", resp); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h04) begin failures++; $display("FAIL simul_full got=%h exp=04", rd); end
    for (int i = 0; i < 4; i++) begin
      ctrl_fetch(w);
      checks++; if (w !== exp_rest[i]) begin failures++; $display("FAIL simul_order%0d got=%h exp=%h", i, w, exp_rest[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic [31:0] words [4];
    words = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = A_DIN; hsize = SZ_WORD;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      hwdata = words[i];
      @(negedge clk);
      checks++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin
        failures++; $display("FAIL b2b_write%0d resp=%b ready=%b exp resp=0 ready=1", i, hresp, hreadyout); end
    end
    // Fifth pipelined write sees the FIFO full.
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hDEAD;
    @(negedge clk);
    checks++; if (hresp !== 1'b1 || hreadyout !== 1'b0) begin
      failures++; $display("FAIL b2b_err1 resp=%b ready=%b exp resp=1 ready=0", hresp, hreadyout); end
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = A_STATUS;
    @(negedge clk);
    checks++; if (hresp !== 1'b1 || hreadyout !== 1'b1) begin
      failures++; $display("FAIL b2b_err2 resp=%b ready=%b exp resp=1 ready=1", hresp, hreadyout); end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    checks++; if (hresp !== 1'b0 || hrdata !== 32'h04) begin
      failures++; $display("FAIL b2b_read_in_err2 resp=%b data=%h exp resp=0 data=04", hresp, hrdata); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ctrl_fetch(w);
      checks++; if (w !== words[i]) begin failures++; $display("FAIL b2b_fetch%0d got=%h exp=%h", i, w, words[i]); end
    end
  endtask

  task automatic test_key_done();
    logic [31:0] rd;
    int resp;
    done_chg_key = 1'b1;
    @(posedge clk); #1;
    done_chg_key = 1'b0;
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h09) begin failures++; $display("FAIL key_set got=%h exp=09", rd); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL key_clear got=%h exp=08", rd); end
    // Set in the same cycle as the clearing read must win.
    done_chg_key = 1'b1;
    @(posedge clk); #1;
    done_chg_key = 1'b0;
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b1, rd, resp);
    checks++; if (rd !== 32'h09) begin failures++; $display("FAIL key_race_read got=%h exp=09", rd); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h09) begin failures++; $display("FAIL key_set_wins got=%h exp=09", rd); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL key_clear2 got=%h exp=08", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    int resp, base;
    base = start_cnt;
    bus_xfer(1'b1, A_CTRL, 32'h3, SZ_BYTE, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL err_hsize resp got=%0d exp=1", resp); end
    checks++; if (start_cnt - base !== 0) begin failures++; $display("FAIL err_hsize_start got=%0d exp=0", start_cnt - base); end
    bus_xfer(1'b0, A_CTRL, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h4) begin failures++; $display("FAIL err_hsize_ctrl got=%h exp=4", rd); end
    bus_xfer(1'b1, A_STATUS, 32'hFF, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL err_wr_status resp got=%0d exp=1", resp); end
    bus_xfer(1'b1, A_DOUT, 32'hFF, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL err_wr_dout resp got=%0d exp=1", resp); end
    bus_xfer(1'b0, A_DIN, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (resp !== 1) begin failures++; $display("FAIL err_rd_din resp got=%0d exp=1", resp); end
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL err_no_side_effect got=%h exp=08", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int resp;
    bus_xfer(1'b1, A_DIN, 32'h77, SZ_WORD, 1'b0, rd, resp);
    checks++; if (core_wdata !== 32'h77) begin failures++; $display("FAIL mid_head got=%h exp=77", core_wdata); end
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = A_DIN; hsize = SZ_WORD;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h88;
    #2 n_rst = 1'b0;
    #1;
    checks++; if (core_wdata !== 32'h0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
      failures++; $display("FAIL mid_async core=%h ready=%b resp=%b exp 0/1/0", core_wdata, hreadyout, hresp); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    bus_xfer(1'b0, A_STATUS, '0, SZ_WORD, 1'b0, rd, resp);
    checks++; if (rd !== 32'h08) begin failures++; $display("FAIL mid_status got=%h exp=08", rd); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_in_fifo();
    test_out_fifo();
    test_simultaneous();
    test_back_to_back();
    test_key_done();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
